// File: rtl/opcode_injector_pkg.sv
// Shared definitions for the trap / opcode-injection CPLD blocks
// (injector, opcode tracker, trap decoder).
package opcode_injector_pkg;

  localparam logic [7:0] OpJp = 8'hC3;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StOp    = 3'd2,
    StLo    = 3'd3,
    StHi    = 3'd4
  } inj_state_e;

endpackage

// File: rtl/z80_cycle_decode.sv
// Classifies Z80 bus cycles from the control strobes and flags the end of any read
// (rd_n sampled high after being sampled low).
module z80_cycle_decode (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic rd_n,
  output logic fetch,
  output logic mem_read,
  output logic refresh,
  output logic rd_end
);

  logic rd_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_n_q <= 1'b1;
    end else begin
      rd_n_q <= rd_n;
    end
  end

  always_comb begin
    fetch    = !m1_n && !mreq_n && !rd_n;
    mem_read = m1_n && !mreq_n && !rd_n;
    refresh  = !mreq_n && rd_n;
    rd_end   = rd_n && !rd_n_q;
  end

endmodule

// File: rtl/opcode_injector.sv
// Forces a 3-byte opcode (JP nn by default) onto the Z80 data bus in place of memory,
// redirecting the CPU into a trap handler at the latched vector.
module opcode_injector
  import opcode_injector_pkg::*;
#(
  parameter logic [7:0] OPCODE = OpJp
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        new_isr,
  input  logic        trap_req,
  input  logic [15:0] trap_vector,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        mem_inhibit,
  output logic        busy,
  output logic        trap_ack
);

  inj_state_e  state_q, state_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        trap_ack_q, trap_ack_d;

  logic fetch, mem_read, refresh, rd_end;

  z80_cycle_decode u_decode (
    .clk      (clk),
    .rst_n    (rst_n),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .rd_n     (rd_n),
    .fetch    (fetch),
    .mem_read (mem_read),
    .refresh  (refresh),
    .rd_end   (rd_end)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    trap_ack_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trap_req) begin
          vec_d   = trap_vector;
          state_d = StArmed;
        end
      end
      StArmed: begin
        // Prefix continuations (new_isr=0) are let through to real memory.
        if (fetch && new_isr) begin
          data_oe_d  = 1'b1;
          data_out_d = OPCODE;
          state_d    = StOp;
        end
      end
      StOp: begin
        if (rd_end && data_oe_q) begin
          data_oe_d = 1'b0;
          state_d   = StLo;
        end
      end
      StLo: begin
        // Gating rd_end on data_oe_q keeps I/O reads from advancing the sequence.
        if (mem_read && !data_oe_q) begin
          data_oe_d  = 1'b1;
          data_out_d = vec_q[7:0];
        end else if (rd_end && data_oe_q) begin
          data_oe_d = 1'b0;
          state_d   = StHi;
        end
      end
      StHi: begin
        if (mem_read && !data_oe_q) begin
          data_oe_d  = 1'b1;
          data_out_d = vec_q[15:8];
        end else if (rd_end && data_oe_q) begin
          data_oe_d  = 1'b0;
          trap_ack_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= 16'h0000;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      trap_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      trap_ack_q <= trap_ack_d;
    end
  end

  // Combinational so the chip selects are blocked before memory can respond.
  always_comb begin
    mem_inhibit = 1'b0;
    unique case (state_q)
      StArmed:          mem_inhibit = new_isr && !m1_n && !mreq_n;
      StOp, StLo, StHi: mem_inhibit = !mreq_n && !refresh;
      default:          mem_inhibit = 1'b0;
    endcase
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign busy     = (state_q != StIdle);
  assign trap_ack = trap_ack_q;

endmodule

// File: tb/tb_opcode_injector.sv
// Bench for opcode_injector: directed scenarios plus random bus traffic, checked against
// a transaction-level model (busy flag, bytes injected so far, latched vector).
module tb_opcode_injector;
  import opcode_injector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m1_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1, new_isr = 1'b0, trap_req = 1'b0;
  logic [15:0] trap_vector = 16'h0000;
  logic [7:0]  data_out;
  logic        data_oe, mem_inhibit, busy, trap_ack;

  int total = 0;
  int bad = 0;

  // Model: injection pending, bytes started (0..3), vector, last driven byte.
  bit          m_busy = 1'b0;
  int          m_idx = 0;
  logic [15:0] m_vec = 16'h0000;
  logic [7:0]  m_last = 8'h00;

  always #5 clk = ~clk;

  opcode_injector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m1_n        (m1_n),
    .mreq_n      (mreq_n),
    .rd_n        (rd_n),
    .new_isr     (new_isr),
    .trap_req    (trap_req),
    .trap_vector (trap_vector),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .mem_inhibit (mem_inhibit),
    .busy        (busy),
    .trap_ack    (trap_ack)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One rising edge; a level request is accepted only when nothing is pending.
  task automatic tick();
    @(posedge clk);
    if (!m_busy && trap_req) begin
      m_busy = 1'b1;
      m_idx  = 0;
      m_vec  = trap_vector;
    end
  endtask

  task automatic request(input logic [15:0] vec);
    @(negedge clk);
    trap_req = 1'b1;
    trap_vector = vec;
    tick();
    #1 chk1("req_busy", busy, m_busy);
    @(negedge clk);
    trap_req = 1'b0;
  endtask

  task automatic m1_cycle(input bit isr, input int waits);
    bit inj;
    @(negedge clk);
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; new_isr = isr;
    #1 chk1("m1_inhibit", mem_inhibit, m_busy && (m_idx > 0 || isr));
    inj = m_busy && m_idx == 0 && isr;
    tick();
    #1;
    if (inj) begin
      m_last = OpJp;
      m_idx  = 1;
    end
    chk1("m1_oe", data_oe, inj);
    chk8("m1_data", data_out, m_last);
    repeat (waits) begin
      tick();
      #1 chk1("m1_wait_oe", data_oe, inj);
    end
    tick();
    @(negedge clk);
    chk1("m1_t3_oe", data_oe, inj);
    chk8("m1_t3_data", data_out, m_last);
    m1_n = 1'b1; rd_n = 1'b1; new_isr = 1'b0;  // refresh: mreq_n stays low
    #1 chk1("rfsh_inhibit", mem_inhibit, 1'b0);
    chk1("rfsh_oe", data_oe, inj);
    tick();
    #1 chk1("m1_end_oe", data_oe, 1'b0);
    @(negedge clk);
    mreq_n = 1'b1;
  endtask

  task automatic mem_read(input int waits);
    bit inj, ack;
    @(negedge clk);
    m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    #1 chk1("rd_inhibit", mem_inhibit, m_busy && m_idx > 0);
    inj = m_busy && (m_idx == 1 || m_idx == 2);
    tick();
    #1;
    if (inj) begin
      m_last = (m_idx == 1) ? m_vec[7:0] : m_vec[15:8];
      m_idx++;
    end
    chk1("rd_oe", data_oe, inj);
    chk8("rd_data", data_out, m_last);
    repeat (waits) begin
      tick();
      #1 chk1("rd_wait_oe", data_oe, inj);
      chk8("rd_wait_data", data_out, m_last);
    end
    tick();
    @(negedge clk);
    chk1("rd_t3_oe", data_oe, inj);
    chk8("rd_t3_data", data_out, m_last);
    rd_n = 1'b1; mreq_n = 1'b1;
    ack = inj && m_idx == 3;
    tick();
    #1;
    if (ack) m_busy = 1'b0;
    chk1("rd_end_oe", data_oe, 1'b0);
    chk1("rd_ack", trap_ack, ack);
    chk1("rd_busy", busy, m_busy);
  endtask

  // I/O read (intack=0) or interrupt acknowledge (intack=1); never a memory read.
  task automatic io_cycle(input bit intack);
    @(negedge clk);
    m1_n = !intack; mreq_n = 1'b1; rd_n = intack;
    #1 chk1("io_inhibit", mem_inhibit, 1'b0);
    tick();
    tick();
    #1 chk1("io_oe", data_oe, 1'b0);
    @(negedge clk);
    m1_n = 1'b1; rd_n = 1'b1;
    tick();
    #1 chk1("io_end_oe", data_oe, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tick();
      #1 chk1("idle_busy", busy, m_busy);
      chk1("idle_ack", trap_ack, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk8("rst_data", data_out, 8'h00);
    chk1("rst_oe", data_oe, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ack", trap_ack, 1'b0);
    chk1("rst_inhibit", mem_inhibit, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic injection: C3 34 12
    request(16'h1234);
    m1_cycle(1'b1, 0);
    chk8("basic_op", m_last, 8'hC3);
    mem_read(0);
    mem_read(0);
    idle(1);

    // Prefix boundary
    request(16'h5678);
    m1_cycle(1'b0, 0);
    m1_cycle(1'b1, 0);
    mem_read(0);
    mem_read(0);

    // Refresh after the opcode fetch, wait states on operands
    request(16'h1234);
    io_cycle(1'b1);
    m1_cycle(1'b1, 1);
    mem_read(2);
    mem_read(1);

    // Request while busy, then re-arm with the vector present at re-arm time
    request(16'h1234);
    m1_cycle(1'b1, 0);
    mem_read(0);
    @(negedge clk);
    trap_req = 1'b1;
    trap_vector = 16'hBEEF;
    mem_read(0);
    trap_vector = 16'hCAFE;
    idle(1);
    trap_req = 1'b0;
    m1_cycle(1'b1, 0);
    mem_read(0);
    chk8("rearm_lo", data_out, 8'hFE);
    mem_read(0);

    // Reset during an operand read with data_oe high
    request(16'h1234);
    m1_cycle(1'b1, 0);
    @(negedge clk);
    m1_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk);
    #1 chk1("prerst_oe", data_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk1("async_rst_oe", data_oe, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    m_busy = 1'b0; m_idx = 0; m_last = 8'h00;
    @(negedge clk);
    rd_n = 1'b1; mreq_n = 1'b1; rst_n = 1'b1;
    m1_cycle(1'b1, 0);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (!m_busy && r < 3) begin
        request(16'($urandom));
      end else if (m_busy && (m_idx == 1 || m_idx == 2)) begin
        if (r < 7) mem_read(int'($urandom_range(0, 2)));
        else io_cycle(r[0]);
      end else begin
        case (r % 5)
          0: m1_cycle(1'($urandom), int'($urandom_range(0, 1)));
          1: mem_read(int'($urandom_range(0, 1)));
          2: io_cycle(r[0]);
          3: request(16'($urandom));
          default: m1_cycle(1'b1, 0);
        endcase
      end
    end
    for (int i = 0; i < 4 && m_busy; i++) begin
      if (m_idx == 0) m1_cycle(1'b1, 0);
      else mem_read(0);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opcode_injector.md
# opcode_injector

Drives a forced `JP nn` (or other 3-byte opcode) onto the Z80 data bus to redirect the CPU into a trap handler. It is the bus-driving counterpart to the opcode tracker, which only observes M1 fetches. Once armed by a trap request, it waits for the next opcode fetch that starts a new instruction. It then supplies the opcode and both operand bytes in place of memory and reports completion to the trap logic.

## Interface
- `OPCODE`, default 8'hC3, opcode byte injected in the M1 cycle (`JP nn`).
- `clk`  in  1  Z80 system clock; all inputs are sampled on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `m1_n`, `mreq_n`, `rd_n`  in  1 each  Z80 bus control strobes, synchronous to `clk`.
- `new_isr`  in  1  from the opcode tracker; high means the current fetch begins a new instruction.
- `trap_req`  in  1  level request to inject.
- `trap_vector`  in  16  jump target, latched on acceptance.
- `data_out`  out  8  byte to drive onto D[7:0].
- `data_oe`  out  1  enables the `data_out` bus driver.
- `mem_inhibit`  out  1  blocks the RAM/ROM chip selects while an injected byte is on the bus.
- `busy`  out  1  high from request acceptance until `trap_ack`.
- `trap_ack`  out  1  one-clock pulse when the third byte has been consumed.

## Operation
- States: IDLE, ARMED, OP, LO, HI.
- IDLE: if `trap_req`=1, latch `trap_vector` into `vec_r` and go to ARMED. `busy` rises with this transition.
- ARMED: a fetch is `m1_n`=0, `mreq_n`=0, `rd_n`=0. On the first sampled fetch with `new_isr`=1, go to OP. Fetches with `new_isr`=0 (prefix continuation) are ignored.
- OP: drive `OPCODE`. On `rd_n` sampled high after being low, go to LO.
- LO: wait for a memory read (`m1_n`=1, `mreq_n`=0, `rd_n`=0). Drive `vec_r[7:0]` and go to HI at the end of the read (`rd_n` rising).
- HI: same as LO, but drive `vec_r[15:8]`. At the end of the read, pulse `trap_ack` and return to IDLE.
- Cycles that are never recognised as reads are ignored in every state:
  - refresh (`mreq_n`=0, `rd_n`=1);
  - interrupt acknowledge (`m1_n`=0 with `mreq_n`=1);
  - I/O cycles.
- `data_oe` is registered: set on the clock a qualifying read is sampled in OP/LO/HI, cleared on the clock `rd_n` is sampled high.
- `data_out` is a mux of `OPCODE`, `vec_r[7:0]` and `vec_r[15:8]` by state. It holds its value while `data_oe`=0.
- `mem_inhibit` is combinational so it precedes the memory response. It is 1 when either holds:
  - state=ARMED, `new_isr`=1, `m1_n`=0, `mreq_n`=0;
  - state is OP, LO or HI, and `mreq_n`=0 and not a refresh.
- `trap_req` is ignored outside IDLE. A request still high after `trap_ack` re-arms on the next clock.
- Reset mid-sequence: state goes to IDLE and `data_oe` drops immediately (async). The CPU then fetches real memory.

## Timing
- Reset values: `data_out`=8'h00, `data_oe`=0, `busy`=0, `trap_ack`=0, `vec_r`=0, state=IDLE. `mem_inhibit` evaluates to 0.
- Request latency: `trap_req` sampled at edge N gives `busy`=1 after edge N. The earliest fetch that can be injected is one sampled at edge N+1.
- M1 fetch:
  - `mreq_n`/`rd_n` fall mid-T1 and are sampled at the T2 rise.
  - `data_oe`=1 from T2 through T3, so the byte is valid at the T3 rise, where the CPU samples it.
  - `rd_n` rises mid-T3, is sampled at the T4 rise, and `data_oe` drops then.
- Operand reads:
  - Sampled at the T2 rise; `data_oe`=1 before the T3 falling edge, where the CPU samples it.
  - Cleared on the first rise after `rd_n` goes high.
- Wait states: `data_oe` holds for as long as `rd_n` stays low; there is no cycle counting.
- Total injection is exactly 3 bus reads. `trap_ack` is 1 clock wide, coincident with the clock `data_oe` clears in HI.

## Structure
- Shared package: state encoding constants and the `JP` opcode constant 8'hC3. The opcode tracker and the trap decoder also use these.
- Bus-cycle classification (fetch / memread / refresh / read-ended edge detect, using a registered `rd_n`) lives in one sub-module, `z80_cycle_decode`. It is reusable by other CPLD blocks.
- The FSM, vector latch and output mux stay in `opcode_injector`.

## Test plan
- Basic injection:
  - Stimulus: reset, `trap_vector`=16'h1234, `trap_req` pulse, then a fetch (`new_isr`=1) and two memory reads.
  - Response: bytes C3, 34, 12 are driven with `mem_inhibit`=1 on each; `trap_ack` is one pulse after the third read; `busy` then drops.
- Prefix boundary:
  - Stimulus: armed, then a fetch with `new_isr`=0, then a fetch with `new_isr`=1.
  - Response: the first fetch is undriven (`data_oe`=0, `mem_inhibit`=0); the second gets C3.
- Refresh and wait states:
  - Stimulus: a refresh cycle between OP and LO; a 2-wait-state operand read.
  - Response: nothing is driven during the refresh; 34 is held for the whole extended read.
- Request while busy:
  - Stimulus: raise `trap_req` with `trap_vector`=16'hBEEF in the middle of a 16'h1234 injection.
  - Response: bytes remain 34/12; a new injection begins only after `trap_ack`, using the vector value present at that re-arm.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during LO with `data_oe`=1.
  - Response: `data_oe`=0 asynchronously, `busy`=0; the next fetch is undriven.
